// File: rtl/kp_pkg.sv
// Shared keypad definitions: key legend, matrix geometry and the emulator state encoding.
// Used by the matrix emulator and by the scanner/decoder side.
package kp_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef logic [3:0] kp_key_t;

    typedef enum logic [2:0] {
        EMU_IDLE         = 3'd0,
        EMU_PRESS_BOUNCE = 3'd1,
        EMU_HOLD         = 3'd2,
        EMU_REL_BOUNCE   = 3'd3,
        EMU_DONE         = 3'd4
    } kp_emu_state_e;

    // Key index = {row, col}; legend follows the usual 1-2-3-A / *-0-#-D telephone layout.
    localparam kp_key_t KEY_1    = 4'h0;
    localparam kp_key_t KEY_2    = 4'h1;
    localparam kp_key_t KEY_3    = 4'h2;
    localparam kp_key_t KEY_A    = 4'h3;
    localparam kp_key_t KEY_4    = 4'h4;
    localparam kp_key_t KEY_5    = 4'h5;
    localparam kp_key_t KEY_6    = 4'h6;
    localparam kp_key_t KEY_B    = 4'h7;
    localparam kp_key_t KEY_7    = 4'h8;
    localparam kp_key_t KEY_8    = 4'h9;
    localparam kp_key_t KEY_9    = 4'hA;
    localparam kp_key_t KEY_C    = 4'hB;
    localparam kp_key_t KEY_STAR = 4'hC;
    localparam kp_key_t KEY_0    = 4'hD;
    localparam kp_key_t KEY_HASH = 4'hE;
    localparam kp_key_t KEY_D    = 4'hF;

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Press-command channel of the keypad matrix emulator (valid/ready handshake).
interface keypad_matrix_emulator_if #(
    parameter int HOLD_W = 16
);
    import kp_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    kp_key_t           cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_bounce;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        output cmd_bounce,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        input  cmd_bounce,
        output cmd_ready
    );

endinterface

// File: rtl/kp_bounce_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) that supplies contact-bounce noise.
module kp_bounce_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= SEED;
        end else begin
            q_reg <= {q_reg[6:0], q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3]};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad matrix responder: turns "press key K for N cycles" commands into a
// registered switch closure and a passive, zero-latency row-to-column matrix.
module keypad_matrix_emulator
    import kp_pkg::*;
#(
    parameter int         BOUNCE_CYCLES = 16,
    parameter int         HOLD_W        = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    keypad_matrix_emulator_if.slave  cmd,
    input  logic [KP_ROWS-1:0]       row,
    output logic [KP_COLS-1:0]       col,
    output logic                     contact,
    output logic                     busy,
    output logic                     done
);

    localparam int BNC_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int CNT_W = (HOLD_W > BNC_W) ? HOLD_W : BNC_W;
    localparam logic [CNT_W-1:0] BNC_LOAD = (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

    localparam logic [2:0] ST_IDLE         = EMU_IDLE;
    localparam logic [2:0] ST_PRESS_BOUNCE = EMU_PRESS_BOUNCE;
    localparam logic [2:0] ST_HOLD         = EMU_HOLD;
    localparam logic [2:0] ST_REL_BOUNCE   = EMU_REL_BOUNCE;
    localparam logic [2:0] ST_DONE         = EMU_DONE;

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              contact_reg, contact_next;
    kp_key_t           key_reg, key_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              bounce_reg, bounce_next;

    logic [HOLD_W-1:0] hold_src;
    logic [CNT_W-1:0]  hold_ext;
    logic [CNT_W-1:0]  hold_load;
    logic              bounce_req;
    logic              cnt_zero;
    logic              lfsr_bit;
    logic [6:0]        lfsr_unused;

    kp_bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   ({lfsr_unused, lfsr_bit})
    );

    // HOLD is entered either straight from IDLE (use the live command) or after the press bounce.
    assign hold_src   = (state_reg == ST_IDLE) ? cmd.cmd_hold : hold_reg;
    assign hold_ext   = CNT_W'(hold_src);
    assign hold_load  = (hold_ext == '0) ? '0 : hold_ext - CNT_W'(1);
    assign bounce_req = cmd.cmd_bounce && (BOUNCE_CYCLES != 0);
    assign cnt_zero   = (cnt_reg == '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        contact_next = contact_reg;
        key_next     = key_reg;
        hold_next    = hold_reg;
        bounce_next  = bounce_reg;
        case (state_reg)
            ST_IDLE: begin
                contact_next = 1'b0;
                if (cmd.cmd_valid) begin
                    key_next    = cmd.cmd_key;
                    hold_next   = cmd.cmd_hold;
                    bounce_next = bounce_req;
                    if (bounce_req) begin
                        state_next   = ST_PRESS_BOUNCE;
                        cnt_next     = BNC_LOAD;
                        contact_next = lfsr_bit;
                    end else begin
                        state_next   = ST_HOLD;
                        cnt_next     = hold_load;
                        contact_next = 1'b1;
                    end
                end
            end
            ST_PRESS_BOUNCE: begin
                if (cnt_zero) begin
                    state_next   = ST_HOLD;
                    cnt_next     = hold_load;
                    contact_next = 1'b1;
                end else begin
                    cnt_next     = cnt_reg - CNT_W'(1);
                    contact_next = lfsr_bit;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    if (bounce_reg) begin
                        state_next   = ST_REL_BOUNCE;
                        cnt_next     = BNC_LOAD;
                        contact_next = lfsr_bit;
                    end else begin
                        state_next   = ST_DONE;
                        cnt_next     = '0;
                        contact_next = 1'b0;
                    end
                end else begin
                    cnt_next     = cnt_reg - CNT_W'(1);
                    contact_next = 1'b1;
                end
            end
            ST_REL_BOUNCE: begin
                if (cnt_zero) begin
                    state_next   = ST_DONE;
                    cnt_next     = '0;
                    contact_next = 1'b0;
                end else begin
                    cnt_next     = cnt_reg - CNT_W'(1);
                    contact_next = lfsr_bit;
                end
            end
            ST_DONE: begin
                state_next   = ST_IDLE;
                contact_next = 1'b0;
            end
            default: begin
                state_next   = ST_IDLE;
                cnt_next     = '0;
                contact_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            contact_reg <= 1'b0;
            key_reg     <= '0;
            hold_reg    <= '0;
            bounce_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            contact_reg <= contact_next;
            key_reg     <= key_next;
            hold_reg    <= hold_next;
            bounce_reg  <= bounce_next;
        end
    end

    assign cmd.cmd_ready = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign contact       = contact_reg;

    // Only the latched key's row is examined, so at most one column can ever be pulled low.
    generate
        for (genvar gi = 0; gi < KP_COLS; gi++) begin : g_col
            assign col[gi] = ~(contact_reg && (key_reg[1:0] == 2'(gi)) && !row[key_reg[3:2]]);
        end
    endgenerate

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: each command pushes its per-cycle
// expected contact/done/ready trace; a negedge monitor pops and compares.
module tb_keypad_matrix_emulator;
    import kp_pkg::*;

    localparam int         BNC  = 16;
    localparam logic [7:0] SEED = 8'hA5;

    typedef struct packed {
        logic       contact;
        logic       done;
        logic       ready;
        logic [3:0] key;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic       contact;
    logic       busy;
    logic       done;

    keypad_matrix_emulator_if #(.HOLD_W(16)) cmd_if ();

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES (BNC),
        .HOLD_W        (16),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .row     (row),
        .col     (col),
        .contact (contact),
        .busy    (busy),
        .done    (done)
    );

    int   checks   = 0;
    int   failures = 0;
    int   done_exp = 0;
    int   done_seen = 0;
    bit   mon_en   = 0;
    exp_t sb_q[$];
    logic [7:0] model_lfsr;
    logic [3:0] row_tbl [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000, 4'b1100, 4'b1010};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge clk) model_lfsr <= rst ? SEED : lfsr_step(model_lfsr);

    // Random row drive, including multi-row and all-ones patterns.
    always @(negedge clk) begin
        #2;
        row = row_tbl[$urandom_range(0, 7)];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic [3:0] col_exp;
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else e = '{contact: 1'b0, done: 1'b0, ready: 1'b1, key: 4'h0};
            col_exp = 4'b1111;
            if (e.contact && !row[e.key[3:2]]) col_exp[e.key[1:0]] = 1'b0;
            check_eq("contact", 32'(contact), 32'(e.contact));
            check_eq("done", 32'(done), 32'(e.done));
            check_eq("cmd_ready", 32'(cmd_if.cmd_ready), 32'(e.ready));
            check_eq("busy", 32'(busy), 32'(!e.ready));
            check_eq("col", 32'(col), 32'(col_exp));
            if (done === 1'b1) done_seen++;
        end
    end

    // Caller is between a negedge and the next posedge; accept happens on the coming edge.
    task automatic send_cmd(input logic [3:0] k, input int h, input bit b);
        logic [7:0] l;
        int n;
        l = model_lfsr;
        n = (h == 0) ? 1 : h;
        if (b) for (int i = 0; i < BNC; i++) begin
            sb_q.push_back('{contact: l[0], done: 1'b0, ready: 1'b0, key: k});
            l = lfsr_step(l);
        end
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{contact: 1'b1, done: 1'b0, ready: 1'b0, key: k});
            l = lfsr_step(l);
        end
        if (b) for (int i = 0; i < BNC; i++) begin
            sb_q.push_back('{contact: l[0], done: 1'b0, ready: 1'b0, key: k});
            l = lfsr_step(l);
        end
        sb_q.push_back('{contact: 1'b0, done: 1'b1, ready: 1'b0, key: k});
        sb_q.push_back('{contact: 1'b0, done: 1'b0, ready: 1'b1, key: k});
        done_exp++;
        $display("cmd key=%0h hold=%0d bounce=%0d lfsr=%02h", k, h, b, model_lfsr);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_key    = k;
        cmd_if.cmd_hold   = 16'(h);
        cmd_if.cmd_bounce = b;
        @(negedge clk);
        #2;
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) check_eq("idle_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic poke_ignored(input logic [3:0] k, input int cycles);
        $display("ignored cmd key=%0h for %0d cycles", k, cycles);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_key    = k;
        cmd_if.cmd_hold   = 16'd3;
        cmd_if.cmd_bounce = 1'b0;
        repeat (cycles) @(negedge clk);
        #2;
        cmd_if.cmd_valid  = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        row               = 4'b1110;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_key    = 4'h0;
        cmd_if.cmd_hold   = 16'd0;
        cmd_if.cmd_bounce = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;

        send_cmd(KEY_1, 10, 1'b0);
        wait_idle(200);
        send_cmd(KEY_6, 16, 1'b1);
        wait_idle(200);

        send_cmd(KEY_6, 20, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        poke_ignored(KEY_D, 3);
        wait_idle(200);

        send_cmd(KEY_D, 0, 1'b0);
        wait_idle(50);
        send_cmd(KEY_A, 1, 1'b1);
        wait_idle(100);
        send_cmd(KEY_STAR, 5, 1'b0);
        wait_idle(50);

        // Reset in the middle of HOLD: command discarded, no done pulse.
        send_cmd(KEY_5, 40, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        $display("reset mid-hold");
        rst = 1'b1;
        sb_q.delete();
        done_exp--;
        @(negedge clk);
        #2;
        rst = 1'b0;
        send_cmd(KEY_9, 4, 1'b1);
        wait_idle(100);

        for (int k = 0; k < 16; k += 5) begin
            send_cmd(4'(k), 3 + k, k[0]);
            wait_idle(100);
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_count", 32'(done_seen), 32'(done_exp));
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
